// File: rtl/not_gate_bist_ctrl_pkg.sv
// Shared types and constants for the not_gate BIST controller.
package not_gate_pkg;

    localparam int unsigned ERR_W = 8;
    localparam logic [ERR_W-1:0] NO_FAIL = 8'hFF;

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_DRIVE  = 2'd1;
    localparam logic [1:0] S_SAMPLE = 2'd2;
    localparam logic [1:0] S_DONE   = 2'd3;

    typedef enum logic [1:0] {
        IDLE   = S_IDLE,
        DRIVE  = S_DRIVE,
        SAMPLE = S_SAMPLE,
        DONE   = S_DONE
    } state_e;

    function automatic logic [ERR_W-1:0] sat_inc(input logic [ERR_W-1:0] v);
        return (v == '1) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/not_gate_bist_ctrl_if.sv
// Handshake and result bundle between the BIST controller and its environment.
interface not_gate_bist_ctrl_if;
    import not_gate_pkg::*;

    logic             start;
    logic             dut_a;
    logic             dut_y;
    logic             busy;
    logic             done;
    logic             pass;
    logic [ERR_W-1:0] err_cnt;
    logic [ERR_W-1:0] fail_step;

    modport master (
        input  start, dut_y,
        output dut_a, busy, done, pass, err_cnt, fail_step
    );

    modport slave (
        output start, dut_y,
        input  dut_a, busy, done, pass, err_cnt, fail_step
    );

endinterface

// File: rtl/not_gate_bist_ctrl.sv
// Self-test sequencer for a single not_gate: drives 0,1,0,... and checks y == ~a.
// Define NOT_GATE_BIST_ERRCNT_EN for the full error counter and first-fail index.
module not_gate_bist_ctrl
    import not_gate_pkg::*;
#(
    parameter int unsigned HOLD_CYCLES = 10,
    parameter int unsigned NUM_STEPS   = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    not_gate_bist_ctrl_if.master  bus
);

    localparam logic [7:0] HOLD_LAST = 8'(HOLD_CYCLES - 1);
    localparam logic [7:0] STEP_LAST = 8'(NUM_STEPS - 1);

    state_e     state_q, state_d;
    logic [7:0] step_q, step_d;
    logic [7:0] hold_q, hold_d;
    logic       dut_a_q, dut_a_d;
    logic       pass_q, pass_d;

    logic       run_start;
    logic       sample_now;
    logic       mismatch;
    logic       any_err_d;

    assign run_start  = (state_q == IDLE) && bus.start;
    assign sample_now = (state_q == SAMPLE);
    assign mismatch   = (bus.dut_y != ~dut_a_q);

    always_comb begin
        state_d = state_q;
        step_d  = step_q;
        hold_d  = hold_q;
        dut_a_d = dut_a_q;
        pass_d  = pass_q;
        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d = DRIVE;
                    step_d  = '0;
                    hold_d  = '0;
                    dut_a_d = 1'b0;
                    pass_d  = 1'b0;
                end
            end
            DRIVE: begin
                hold_d = hold_q + 8'd1;
                if (hold_q == HOLD_LAST) begin
                    state_d = SAMPLE;
                end
            end
            SAMPLE: begin
                if (step_q == STEP_LAST) begin
                    state_d = DONE;
                    dut_a_d = 1'b0;
                    // any_err_d already folds in this final sample
                    pass_d  = ~any_err_d;
                end else begin
                    state_d = DRIVE;
                    step_d  = step_q + 8'd1;
                    hold_d  = '0;
                    dut_a_d = ~dut_a_q;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            step_q  <= '0;
            hold_q  <= '0;
            dut_a_q <= 1'b0;
            pass_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            step_q  <= step_d;
            hold_q  <= hold_d;
            dut_a_q <= dut_a_d;
            pass_q  <= pass_d;
        end
    end

`ifdef NOT_GATE_BIST_ERRCNT_EN
    logic [ERR_W-1:0] err_q, err_d;
    logic [ERR_W-1:0] fail_q, fail_d;

    always_comb begin
        err_d  = err_q;
        fail_d = fail_q;
        if (run_start) begin
            err_d  = '0;
            fail_d = NO_FAIL;
        end else if (sample_now && mismatch) begin
            err_d = sat_inc(err_q);
            if (fail_q == NO_FAIL) begin
                fail_d = step_q;
            end
        end
    end

    assign any_err_d = (err_d != '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            err_q  <= '0;
            fail_q <= NO_FAIL;
        end else begin
            err_q  <= err_d;
            fail_q <= fail_d;
        end
    end

    assign bus.err_cnt   = err_q;
    assign bus.fail_step = fail_q;
`else
    logic flag_q, flag_d;

    always_comb begin
        flag_d = flag_q;
        if (run_start) begin
            flag_d = 1'b0;
        end else if (sample_now && mismatch) begin
            flag_d = 1'b1;
        end
    end

    assign any_err_d = flag_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            flag_q <= 1'b0;
        end else begin
            flag_q <= flag_d;
        end
    end

    assign bus.err_cnt   = '0;
    assign bus.fail_step = NO_FAIL;
`endif

    assign bus.dut_a = dut_a_q;
    assign bus.busy  = (state_q != IDLE);
    assign bus.done  = (state_q == DONE);
    assign bus.pass  = pass_q;

endmodule

// File: tb/tb_not_gate_bist_ctrl.sv
// Scoreboard bench for not_gate_bist_ctrl with a behavioural not_gate and stuck-at faults.
module tb_not_gate_bist_ctrl;

    localparam int H = 10;
    localparam int N = 3;
    localparam int RUN_LEN = N * (H + 1);

    typedef struct {
        logic       pass;
        logic [7:0] err;
        logic [7:0] fail;
    } exp_t;

    logic clk;
    logic rst;
    int   fault;
    int   checks;
    int   errors;
    exp_t sb[$];

    not_gate_bist_ctrl_if bus ();

    not_gate_bist_ctrl #(
        .HOLD_CYCLES(H),
        .NUM_STEPS(N)
    ) u_dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    // fault 0: good inverter, 1: output stuck-at-0, 2: output stuck-at-1
    assign bus.dut_y = (fault == 0) ? ~bus.dut_a : ((fault == 1) ? 1'b0 : 1'b1);

    always #5 clk = ~clk;

    function automatic exp_t model(input int f);
        exp_t e;
        int   cnt;
        int   first;
        logic a;
        logic y;
        cnt   = 0;
        first = -1;
        for (int s = 0; s < N; s++) begin
            a = ((s % 2) == 1);
            y = (f == 0) ? !a : ((f == 1) ? 1'b0 : 1'b1);
            if (y == a) begin
                cnt++;
                if (first < 0) first = s;
            end
        end
        e.pass = (cnt == 0);
`ifdef NOT_GATE_BIST_ERRCNT_EN
        e.err  = (cnt > 255) ? 8'hFF : 8'(cnt);
        e.fail = (first < 0) ? 8'hFF : 8'(first);
`else
        e.err  = 8'h00;
        e.fail = 8'hFF;
`endif
        return e;
    endfunction

    task automatic check_result(input string name);
        exp_t e;
        if (sb.size() == 0) begin
            errors++;
            $display("FAIL %s: done with empty scoreboard", name);
            return;
        end
        e = sb.pop_front();
        checks++;
        if (bus.pass !== e.pass) begin
            errors++;
            $display("FAIL %s pass: got %b want %b", name, bus.pass, e.pass);
        end
        checks++;
        if (bus.err_cnt !== e.err) begin
            errors++;
            $display("FAIL %s err_cnt: got %0d want %0d", name, bus.err_cnt, e.err);
        end
        checks++;
        if (bus.fail_step !== e.fail) begin
            errors++;
            $display("FAIL %s fail_step: got %h want %h", name, bus.fail_step, e.fail);
        end
    endtask

    // c counts rising edges after the one that samples start (c=0);
    // done is registered at edge RUN_LEN and so is seen by edge RUN_LEN+1.
    task automatic run_one(input string name, input int f, input int extra_at, input int rst_at);
        int   c;
        bit   seen;
        logic ea;
        fault = f;
        if (rst_at < 0) sb.push_back(model(f));
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        c    = 0;
        seen = 0;
        while (!seen && c <= RUN_LEN + 5) begin
            if (rst_at >= 0 && c == rst_at + 1) begin
                checks++;
                if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.dut_a !== 1'b0 ||
                    bus.pass !== 1'b0 || bus.err_cnt !== 8'h00 || bus.fail_step !== 8'hFF) begin
                    errors++;
                    $display("FAIL %s abort: busy=%b done=%b a=%b pass=%b err=%0d fs=%h want 0 0 0 0 0 ff",
                             name, bus.busy, bus.done, bus.dut_a, bus.pass, bus.err_cnt, bus.fail_step);
                end
                rst = 1'b0;
                @(negedge clk);
                checks++;
                if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
                    errors++;
                    $display("FAIL %s post-abort: done=%b busy=%b want 0 0", name, bus.done, bus.busy);
                end
                return;
            end
            if (c < RUN_LEN) begin
                ea = (((c / (H + 1)) % 2) == 1);
                checks++;
                if (bus.dut_a !== ea || bus.busy !== 1'b1 || bus.done !== 1'b0 || bus.pass !== 1'b0) begin
                    errors++;
                    $display("FAIL %s cyc %0d: a=%b busy=%b done=%b pass=%b want a=%b busy=1 done=0 pass=0",
                             name, c, bus.dut_a, bus.busy, bus.done, bus.pass, ea);
                end
            end else if (c == RUN_LEN) begin
                checks++;
                if (bus.done !== 1'b1 || bus.busy !== 1'b1 || bus.dut_a !== 1'b0) begin
                    errors++;
                    $display("FAIL %s done cyc: done=%b busy=%b a=%b want 1 1 0",
                             name, bus.done, bus.busy, bus.dut_a);
                end
                if (bus.done === 1'b1) begin
                    check_result(name);
                    seen = 1;
                end
            end
            if (c == extra_at) bus.start = 1'b1;
            else if (c == extra_at + 1) bus.start = 1'b0;
            if (c == rst_at) rst = 1'b1;
            if (!seen) begin
                @(negedge clk);
                c++;
            end
        end
        if (!seen) begin
            errors++;
            $display("FAIL %s timeout: no done within %0d cycles", name, RUN_LEN + 5);
            return;
        end
        @(negedge clk);
        checks++;
        if (bus.done !== 1'b0 || bus.busy !== 1'b0 || bus.pass !== model(f).pass) begin
            errors++;
            $display("FAIL %s after done: done=%b busy=%b pass=%b want 0 0 %b",
                     name, bus.done, bus.busy, bus.pass, model(f).pass);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.start = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.dut_a !== 1'b0 ||
            bus.pass !== 1'b0 || bus.err_cnt !== 8'h00 || bus.fail_step !== 8'hFF) begin
            errors++;
            $display("FAIL reset: busy=%b done=%b a=%b pass=%b err=%0d fs=%h want 0 0 0 0 0 ff",
                     bus.busy, bus.done, bus.dut_a, bus.pass, bus.err_cnt, bus.fail_step);
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_good();
        run_one("good", 0, -1, -1);
    endtask

    task automatic test_stuck();
        run_one("stuck0", 1, -1, -1);
        run_one("stuck1", 2, -1, -1);
    endtask

    task automatic test_start_while_busy();
        run_one("start_busy", 0, 4, -1);
        repeat (3) @(negedge clk);
        checks++;
        if (bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL start_busy rerun: busy=%b want 0", bus.busy);
        end
    endtask

    task automatic test_reset_mid_run();
        run_one("stuck_abort", 1, -1, 14);
        run_one("after_abort", 0, -1, -1);
    endtask

    task automatic test_back_to_back();
        int c;
        int ndone;
        int last;
        fault = 0;
        for (int i = 0; i < 3; i++) sb.push_back(model(0));
        bus.start = 1'b1;
        @(negedge clk);
        c     = 0;
        ndone = 0;
        last  = -1;
        while (ndone < 3 && c < 200) begin
            if (bus.done === 1'b1) begin
                check_result("b2b");
                checks++;
                if ((ndone == 0 && c != RUN_LEN) || (ndone > 0 && c - last != RUN_LEN + 2)) begin
                    errors++;
                    $display("FAIL b2b spacing run %0d: done at %0d prev %0d want first %0d period %0d",
                             ndone, c, last, RUN_LEN, RUN_LEN + 2);
                end
                last = c;
                ndone++;
                if (ndone == 3) bus.start = 1'b0;
            end
            @(negedge clk);
            c++;
        end
        bus.start = 1'b0;
        if (ndone < 3) begin
            errors++;
            $display("FAIL b2b timeout: %0d of 3 done pulses", ndone);
        end
        repeat (3) @(negedge clk);
        checks++;
        if (bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL b2b stop: busy=%b want 0", bus.busy);
        end
    endtask

    initial begin
        clk       = 1'b0;
        rst       = 1'b1;
        fault     = 0;
        checks    = 0;
        errors    = 0;
        bus.start = 1'b0;
        test_reset();
        test_good();
        test_stuck();
        test_start_while_busy();
        test_reset_mid_run();
        test_back_to_back();
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard: %0d results never produced", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/not_gate_bist_ctrl.md
NOT_GATE_BIST_CTRL -- requirements
Module: not_gate_bist_ctrl

Interface
REQ-001 SHALL have parameter HOLD_CYCLES, default 10: cycles each stimulus value is held before sampling; legal range 2..255.
REQ-002 SHALL have parameter NUM_STEPS, default 3: number of stimulus steps per run; legal range 1..255.
REQ-003 SHALL use one clock; reset is synchronous and active-high.
REQ-004 clk  in  1  rising-edge clock for all state.
REQ-005 rst  in  1  synchronous active-high reset.
REQ-006 start  in  1  request a self-test run; sampled only in IDLE.
REQ-007 dut_a  out  1  registered drive to the not_gate input a.
REQ-008 dut_y  in  1  not_gate output y.
REQ-009 busy  out  1  high in DRIVE, SAMPLE and DONE.
REQ-010 done  out  1  one-cycle pulse at end of run.
REQ-011 pass  out  1  result of last completed run, held until next run starts.
REQ-012 err_cnt  out  8  mismatch count of current or last run.
REQ-013 fail_step  out  8  index of first failing step; 8'hFF = none.

Function
REQ-014 SHALL implement FSM states IDLE, DRIVE, SAMPLE, DONE.
REQ-015 IDLE: start=1 -> DRIVE; step=0, hold count=0, dut_a=0, err_cnt=0, fail_step=8'hFF, pass=0.
REQ-016 DRIVE: hold count increments each cycle; at count==HOLD_CYCLES-1 -> SAMPLE.
REQ-017 SAMPLE (one cycle): mismatch when dut_y != ~dut_a; on mismatch err_cnt increments (saturating at 255); fail_step is loaded with step only if still 8'hFF.
REQ-018 SAMPLE: if step==NUM_STEPS-1 -> DONE; else step+1, dut_a toggles, hold count=0 -> DRIVE.
REQ-019 DONE (one cycle): done=1, pass=(err_cnt==0 including the final sample) -> IDLE; dut_a returns to 0.
REQ-020 Stimulus sequence SHALL be 0,1,0,1,... starting at 0.
REQ-021 Latency: with start sampled at cycle 0, done SHALL be high at cycle NUM_STEPS*(HOLD_CYCLES+1)+1 (34 at defaults).
REQ-022 start while busy SHALL be ignored with no effect on the run.
REQ-023 start held high SHALL produce back-to-back runs with period NUM_STEPS*(HOLD_CYCLES+1)+2 cycles.

Reset
REQ-024 rst SHALL force IDLE; dut_a=0, busy=0, done=0, pass=0, err_cnt=0, fail_step=8'hFF; step and hold count=0.
REQ-025 rst mid-run SHALL abort without a done pulse; the next start SHALL give a complete clean run.

Configuration
REQ-026 With NOT_GATE_BIST_ERRCNT_EN defined: err_cnt and fail_step SHALL behave per REQ-017.
REQ-027 Without NOT_GATE_BIST_ERRCNT_EN: err_cnt SHALL be constant 0 and fail_step constant 8'hFF; pass SHALL derive from a 1-bit sticky mismatch flag cleared on run start; all timing is unchanged.

Structure
REQ-028 Package not_gate_pkg SHALL hold the FSM state enum, ERR_W=8 and NO_FAIL=8'hFF.
REQ-029 No sub-module; the hold and step counters are inline. The not_gate instance lives in the enclosing bench or top level.

Verification
REQ-030 Good not_gate, defaults, start at cycle 0 -> dut_a 0/1/0 for 11 cycles each; done at cycle 34; pass=1, err_cnt=0, fail_step=8'hFF.
REQ-031 dut_y stuck-at-0 -> err_cnt=2, fail_step=0, pass=0.
REQ-032 dut_y stuck-at-1 -> err_cnt=1, fail_step=1, pass=0.
REQ-033 Extra start pulse at cycle 5 -> ignored; exactly one done, at cycle 34.
REQ-034 rst at cycle 15 -> reset values next cycle, no done; restart -> clean pass at 34 cycles after start.
REQ-035 start held high, good not_gate -> done pulses 35 cycles apart; pass=1 each run.
